// File: rtl/mmio_console_if.sv
// Core data-memory port bundle as seen by the console responder.
interface mmio_console_if;
  logic        dmem_wready;
  logic        dmem_wvalid;
  logic [31:0] dmem_waddr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        w_hit;
  logic        dmem_rready;
  logic        dmem_rvalid;
  logic [31:0] dmem_raddr;
  logic        r_hit;
  logic        dmem_rresp;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_wready, dmem_waddr, dmem_wdata, dmem_wstrb, dmem_rready, dmem_raddr,
    input  dmem_wvalid, w_hit, dmem_rvalid, r_hit, dmem_rresp, dmem_rdata
  );
  modport slave (
    input  dmem_wready, dmem_waddr, dmem_wdata, dmem_wstrb, dmem_rready, dmem_raddr,
    output dmem_wvalid, w_hit, dmem_rvalid, r_hit, dmem_rresp, dmem_rdata
  );
endinterface

// File: rtl/mmio_console.sv
// Console MMIO responder: PUTC writes feed a char FIFO drained by an 8N1 UART,
// EXIT writes latch a sticky exit code, STAT reads return FIFO/TX/exit status.
module mmio_console #(
  parameter int          CLK_DIV    = 16,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [31:0] PUTC_ADDR  = 32'h9000001c,
  parameter logic [31:0] EXIT_ADDR  = 32'h9000002c,
  parameter logic [31:0] STAT_ADDR  = 32'h90000030
) (
  input  logic         clk,
  input  logic         reset,
  mmio_console_if.slave bus,
  output logic         uart_tx,
  output logic         exit_valid,
  output logic [31:0]  exit_code
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, push, pop;
  logic          putc_hit, exit_hit, w_acc;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          tx_d, div_end;
  logic [31:0]   stat;

  assign full  = (count == (AW+1)'(FIFO_DEPTH));
  assign empty = (count == '0);

  assign putc_hit        = (bus.dmem_waddr == PUTC_ADDR);
  assign exit_hit        = (bus.dmem_waddr == EXIT_ADDR);
  assign bus.w_hit       = putc_hit | exit_hit;
  assign bus.dmem_wvalid = !(putc_hit && full);
  assign w_acc           = bus.dmem_wready && bus.w_hit && bus.dmem_wvalid;
  assign push            = w_acc && putc_hit && bus.dmem_wstrb[0];

  assign bus.r_hit       = (bus.dmem_raddr == STAT_ADDR);
  assign bus.dmem_rvalid = 1'b1;
  assign stat = {20'd0, exit_valid, state_q != IDLE, full, empty, 8'(count)};

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= bus.dmem_wdata[7:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      exit_valid     <= 1'b0;
      exit_code      <= '0;
      bus.dmem_rresp <= 1'b0;
      bus.dmem_rdata <= '0;
    end else begin
      if (w_acc && exit_hit && !exit_valid) begin
        exit_valid <= 1'b1;
        exit_code  <= bus.dmem_wdata;
      end
      bus.dmem_rresp <= bus.dmem_rready && bus.r_hit;
      if (bus.dmem_rready && bus.r_hit) bus.dmem_rdata <= stat;
    end
  end

  assign div_end = (div_q == DW'(CLK_DIV - 1));

  always_comb begin
    state_d = state_q;
    div_d   = div_q + 1'b1;
    bit_d   = bit_q;
    sh_d    = sh_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        div_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          sh_d    = mem[rd_ptr];
          state_d = START;
        end
      end
      START: if (div_end) begin
        state_d = DATA;
        div_d   = '0;
        bit_d   = '0;
      end
      DATA: if (div_end) begin
        div_d = '0;
        if (bit_q == 3'd7) state_d = STOP;
        else               bit_d   = bit_q + 3'd1;
      end
      default: if (div_end) begin
        state_d = IDLE;
        div_d   = '0;
      end
    endcase
    // line level registered from the next state so it tracks state_q exactly
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = sh_d[bit_d];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      uart_tx <= 1'b1;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      uart_tx <= tx_d;
    end
  end
endmodule

// File: tb/tb_mmio_console.sv
// Randomized scoreboard bench for mmio_console: UART frames and status reads are
// checked by independent monitors against queues filled by the stimulus.
module tb_mmio_console;
  localparam int          CD    = 4;
  localparam int          DEPTH = 16;
  localparam logic [31:0] PUTC  = 32'h9000001c;
  localparam logic [31:0] EXITA = 32'h9000002c;
  localparam logic [31:0] STAT  = 32'h90000030;

  logic        clk = 0;
  logic        reset = 1;
  logic        uart_tx, exit_valid;
  logic [31:0] exit_code;

  mmio_console_if bus ();

  mmio_console #(.CLK_DIV(CD), .FIFO_DEPTH(DEPTH), .PUTC_ADDR(PUTC),
                 .EXIT_ADDR(EXITA), .STAT_ADDR(STAT)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave),
    .uart_tx(uart_tx), .exit_valid(exit_valid), .exit_code(exit_code));

  always #5 clk = ~clk;

  int          checks = 0, passes = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] rd_q[$];
  logic        m_exit = 0;
  logic [31:0] m_code = 0;
  logic [31:0] last_rdata = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // read monitor: every response must match the oldest expected status
  always @(negedge clk) begin
    if (bus.dmem_rresp === 1'b1) begin
      if (rd_q.size() == 0) chk("rresp_unexpected", 1, 0);
      else chk("status_rdata", bus.dmem_rdata, rd_q.pop_front());
      last_rdata = bus.dmem_rdata;
    end
  end

  // line monitor: samples a whole frame cycle by cycle against an ideal 8N1 frame
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && uart_tx === 1'b0) begin
        logic [7:0] exp_b, got_b;
        logic [9:0] frame;
        int errs;
        logic aborted, have;
        have = exp_q.size() != 0;
        exp_b = have ? exp_q[0] : 8'h00;
        frame = {1'b1, exp_b, 1'b0};
        errs = 0; aborted = 0; got_b = '0;
        for (int k = 0; k < 10*CD; k++) begin
          if (k != 0) @(negedge clk);
          if (reset) begin aborted = 1; break; end
          if (uart_tx !== frame[k/CD]) errs++;
          if (k % CD == CD/2 && k/CD >= 1 && k/CD <= 8) got_b[k/CD-1] = uart_tx;
        end
        if (!aborted) begin
          if (!have) chk("frame_unexpected", {24'd0, got_b}, 32'hffffffff);
          else begin
            void'(exp_q.pop_front());
            chk("frame_byte", {24'd0, got_b}, {24'd0, exp_b});
            chk("frame_timing_errs", errs, 0);
          end
        end
      end
    end
  end

  task automatic idle_cycles(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // starts and ends 1 time unit after a rising edge
  task automatic wr(logic [31:0] addr, logic [31:0] data, logic [3:0] strb, output int stalls);
    logic hit;
    hit = (addr == PUTC) || (addr == EXITA);
    stalls = 0;
    bus.dmem_wready = 1; bus.dmem_waddr = addr; bus.dmem_wdata = data; bus.dmem_wstrb = strb;
    @(negedge clk);
    chk("w_hit", bus.w_hit, hit);
    if (hit) begin
      while (bus.dmem_wvalid !== 1'b1 && stalls < 2000) begin
        stalls++;
        @(posedge clk); #1;
        @(negedge clk);
      end
      if (stalls >= 2000) chk("write_accept_timeout", 0, 1);
      else begin
        if (addr == PUTC && strb[0]) exp_q.push_back(data[7:0]);
        if (addr == EXITA && !m_exit) begin m_exit = 1; m_code = data; end
      end
    end
    @(posedge clk); #1;
    bus.dmem_wready = 0;
  endtask

  task automatic rd(logic [31:0] addr, logic [31:0] exp);
    bus.dmem_rready = 1; bus.dmem_raddr = addr;
    if (addr == STAT) rd_q.push_back(exp);
    @(negedge clk);
    chk("r_hit", bus.r_hit, addr == STAT);
    @(posedge clk); #1;
    bus.dmem_rready = 0;
  endtask

  function automatic logic [31:0] quiet_stat();
    return 32'h100 | (m_exit ? 32'h800 : 32'h0);
  endfunction

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || rd_q.size() != 0) && n < 20000) begin
      @(posedge clk); n++;
    end
    if (n >= 20000) chk("drain_timeout", exp_q.size(), 0);
    idle_cycles(3);
  endtask

  task automatic do_reset();
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    exp_q.delete(); rd_q.delete();
    m_exit = 0; m_code = 0; last_rdata = 0;
    @(negedge clk);
    chk("rst_uart_tx", uart_tx, 1);
    chk("rst_exit_valid", exit_valid, 0);
    chk("rst_exit_code", exit_code, 0);
    chk("rst_rresp", bus.dmem_rresp, 0);
    chk("rst_rdata", bus.dmem_rdata, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int st, stall_sum, lows, n;
    bus.dmem_wready = 0; bus.dmem_waddr = 0; bus.dmem_wdata = 0; bus.dmem_wstrb = 0;
    bus.dmem_rready = 0; bus.dmem_raddr = 0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // idle status and a single response pulse
    rd(STAT, 32'h100);
    idle_cycles(4);

    // 'A' on the line: start bit must appear right after the pop edge
    wr(PUTC, 32'h41, 4'hf, st);
    @(negedge clk); chk("tx_before_pop", uart_tx, 1);
    @(negedge clk); chk("tx_start_after_pop", uart_tx, 0);
    @(posedge clk); #1;
    drain();

    // low strobe byte clear: accepted, nothing queued
    wr(PUTC, 32'h55, 4'b0010, st);
    chk("strb_no_stall", st, 0);
    idle_cycles(10);
    rd(STAT, quiet_stat());
    drain();

    // fill the FIFO back to back, then overflow into back-pressure
    stall_sum = 0;
    for (int i = 0; i < 17; i++) begin
      wr(PUTC, $urandom, 4'h1, st);
      if (i < 16) stall_sum += st;
    end
    chk("fill_no_stall", stall_sum, 0);
    rd(STAT, 32'h610 | (m_exit ? 32'h800 : 32'h0));
    wr(PUTC, $urandom, 4'h1, st);
    chk("full_backpressure", st > 0, 1);
    drain();

    // random mix of PUTC, dropped-byte PUTC, missed writes and missed reads
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0, 1: wr(PUTC, $urandom, 4'($urandom_range(0, 15)), st);
        2:    wr($urandom | 32'h1, $urandom, 4'hf, st);
        default: begin
          rd(STAT + 32'd4, 0);
          @(negedge clk);
          chk("miss_no_rresp", bus.dmem_rresp, 0);
          chk("miss_rdata_hold", bus.dmem_rdata, last_rdata);
          @(posedge clk); #1;
        end
      endcase
      idle_cycles($urandom_range(0, 3));
    end
    drain();
    rd(STAT, quiet_stat());
    drain();

    // exit: first code sticks, later writes ignored, PUTC still works
    wr(EXITA, 32'h2a, 4'hf, st);
    @(negedge clk); chk("exit_valid", exit_valid, 1);
    @(posedge clk); #1;
    wr(EXITA, 32'h5, 4'hf, st);
    idle_cycles(2);
    chk("exit_code_sticky", exit_code, 32'h2a);
    rd(STAT, 32'h900);
    wr(PUTC, 32'h7e, 4'h1, st);
    drain();

    // reset in the middle of DATA bit 3 abandons the frame
    wr(PUTC, 32'h41, 4'h1, st);
    n = 0;
    do begin @(negedge clk); n++; end while (uart_tx !== 1'b0 && n < 100);
    chk("frame_start_seen", uart_tx, 0);
    repeat (4*CD) @(posedge clk);
    #1;
    do_reset();
    rd(STAT, 32'h100);
    lows = 0;
    repeat (60) begin @(negedge clk); if (uart_tx !== 1'b1) lows++; end
    chk("line_quiet_after_reset", lows, 0);
    chk("queue_empty_after_reset", rd_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
